// File: rtl/fabric_pkg.sv
// Shared definitions for the multi-channel fabric memory target.
// Response codes, address-width helper and flattened-bus slicing.
package fabric_pkg;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  localparam int BUS_MAX   = 4096;
  localparam int SLICE_MAX = 256;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Caller zero-extends the bus to BUS_MAX and truncates the result.
  function automatic logic [SLICE_MAX-1:0] ch_slice(
    input logic [BUS_MAX-1:0] bus,
    input int                 idx,
    input int                 w
  );
    return SLICE_MAX'(bus >> (idx * w));
  endfunction

endpackage

// File: rtl/fabric_rr_arb.sv
// Round-robin arbiter: search starts at rr_ptr, pointer moves past
// the winner only when the grant is actually taken.
module fabric_rr_arb #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr_q;
  logic          found;
  int            c;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    c         = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr_q) + k;
      if (c >= N) c = c - N;
      if (!found && req[IW'(c)]) begin
        found          = 1'b1;
        grant[IW'(c)]  = 1'b1;
        grant_idx      = IW'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fabric_mc_mem.sv
// Shared DEPTH x WIDTH memory serving NUM_CH requesters through a
// round-robin arbiter, with a registered response per channel.
module fabric_mc_mem
  import fabric_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int NUM_CH = 4,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*WIDTH-1:0]  req_wdata,
  output logic [NUM_CH-1:0]        resp_valid,
  input  logic [NUM_CH-1:0]        resp_ready,
  output logic [NUM_CH-1:0]        resp_err,
  output logic [NUM_CH*WIDTH-1:0]  resp_rdata
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]       elig;
  logic [NUM_CH-1:0]       grant;
  logic [CH_W-1:0]         gidx;
  logic                    acc;
  logic [NUM_CH-1:0]       valid_q;
  logic [NUM_CH-1:0]       err_q;
  logic [NUM_CH*WIDTH-1:0] rdata_q;
  logic [BUS_MAX-1:0]      abus;
  logic [BUS_MAX-1:0]      wbus;
  logic [ADDR_W-1:0]       addr_g;
  logic [WIDTH-1:0]        wdata_g;
  logic [WIDTH-1:0]        rdata_d;
  logic                    wr_g;
  logic                    err_d;
  logic [WIDTH-1:0]        mem_q [DEPTH];

  // A stalled response blocks its channel; nothing is granted in reset.
  assign elig = rst ? '0 : (req_valid & (~valid_q | resp_ready));

  fabric_rr_arb #(.N(NUM_CH)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (elig),
    .advance   (acc),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign acc       = |grant;
  assign req_ready = grant;

  assign abus    = BUS_MAX'(req_addr);
  assign wbus    = BUS_MAX'(req_wdata);
  assign addr_g  = ADDR_W'(ch_slice(abus, int'(gidx), ADDR_W));
  assign wdata_g = WIDTH'(ch_slice(wbus, int'(gidx), WIDTH));
  assign wr_g    = req_write[gidx];
  assign err_d   = (32'(addr_g) >= 32'(DEPTH)) ? RESP_ERR : RESP_OK;

  always_comb begin
    rdata_d = '0;
    if (!wr_g && err_d == RESP_OK) rdata_d = mem_q[addr_g];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (grant[i]) begin
          valid_q[i]                <= 1'b1;
          err_q[i]                  <= err_d;
          rdata_q[i*WIDTH +: WIDTH] <= rdata_d;
        end else if (resp_ready[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
      if (acc && wr_g && err_d == RESP_OK) mem_q[addr_g] <= wdata_g;
    end
  end

  assign resp_valid = valid_q;
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_fabric_mc_mem.sv
// Bench for fabric_mc_mem: DEPTH=16 and DEPTH=12 instances share
// stimulus and are checked against a queue/array reference model.
module tb_fabric_mc_mem;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   rv, wr, rr;
  logic [15:0]  ad;
  logic [127:0] wd;

  logic [3:0]   rdy [2];
  logic [3:0]   rvl [2];
  logic [3:0]   rer [2];
  logic [127:0] rdt [2];

  always #5 clk = ~clk;

  fabric_mc_mem #(.WIDTH(32), .DEPTH(16), .NUM_CH(4)) u16 (
    .clk(clk), .rst(rst), .req_valid(rv), .req_ready(rdy[0]),
    .req_write(wr), .req_addr(ad), .req_wdata(wd),
    .resp_valid(rvl[0]), .resp_ready(rr), .resp_err(rer[0]),
    .resp_rdata(rdt[0])
  );

  fabric_mc_mem #(.WIDTH(32), .DEPTH(12), .NUM_CH(4)) u12 (
    .clk(clk), .rst(rst), .req_valid(rv), .req_ready(rdy[1]),
    .req_write(wr), .req_addr(ad), .req_wdata(wd),
    .resp_valid(rvl[1]), .resp_ready(rr), .resp_err(rer[1]),
    .resp_rdata(rdt[1])
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  int          dep [2] = '{16, 12};
  logic [31:0] mem [2][16];
  bit          mv  [2][4];
  bit          me  [2][4];
  logic [31:0] md  [2][4];
  int          ptr;
  int          last_g;
  logic [3:0]  last_rdy;

  typedef struct {
    bit         rst;
    logic [3:0] rv;
    logic [3:0] rr;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 16; a++) mem[d][a] = '0;
      for (int i = 0; i < 4; i++) begin
        mv[d][i] = 0;
        me[d][i] = 0;
        md[d][i] = '0;
      end
    end
    ptr = 0;
  endtask

  task automatic drive(input bit r, input logic [3:0] v, input logic [3:0] w,
                       input logic [3:0] q, input logic [15:0] a,
                       input logic [127:0] d);
    rst = r; rv = v; wr = w; rr = q; ad = a; wd = d;
  endtask

  task automatic one(input int ch, input bit w, input int a,
                     input logic [31:0] d, input logic [3:0] q);
    rst = 1'b0;
    rv = '0; rv[ch] = 1'b1;
    wr = '0; wr[ch] = w;
    ad = '0; ad[ch*4 +: 4] = 4'(a);
    wd = '0; wd[ch*32 +: 32] = d;
    rr = q;
  endtask

  // Check outputs mid-cycle, then advance the model across the edge.
  task automatic do_cycle();
    int         gi;
    int         a;
    int         c;
    bit         e;
    logic [3:0] exp_r;
    logic [3:0] exp_v;
    @(negedge clk);
    gi    = -1;
    exp_r = '0;
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        c = (ptr + k) % 4;
        if (gi < 0 && rv[c] && (!mv[0][c] || rr[c])) gi = c;
      end
    end
    if (gi >= 0) exp_r[gi] = 1'b1;
    last_rdy = rdy[0];
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("req_ready_d%0d", dep[d]), 32'(rdy[d]), 32'(exp_r));
      exp_v = '0;
      for (int i = 0; i < 4; i++) exp_v[i] = mv[d][i];
      chk($sformatf("resp_valid_d%0d", dep[d]), 32'(rvl[d]), 32'(exp_v));
      for (int i = 0; i < 4; i++) begin
        if (mv[d][i]) begin
          chk($sformatf("resp_err_d%0d_ch%0d", dep[d], i),
              32'(rer[d][i]), 32'(me[d][i]));
          chk($sformatf("resp_rdata_d%0d_ch%0d", dep[d], i),
              rdt[d][i*32 +: 32], md[d][i]);
        end
      end
    end
    if (rst) begin
      model_reset();
    end else begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 4; i++)
          if (mv[d][i] && rr[i]) mv[d][i] = 0;
      if (gi >= 0) begin
        a = int'(ad[gi*4 +: 4]);
        for (int d = 0; d < 2; d++) begin
          e = (a >= dep[d]);
          mv[d][gi] = 1;
          me[d][gi] = e;
          if (wr[gi]) begin
            md[d][gi] = '0;
            if (!e) mem[d][a] = wd[gi*32 +: 32];
          end else begin
            md[d][gi] = e ? 32'h0 : mem[d][a];
          end
        end
        ptr = (gi + 1) % 4;
      end
    end
    last_g = gi;
    @(posedge clk);
    #1;
  endtask

  int ch0_acc;

  initial begin
    tbl[0]  = '{1'b1, 4'b1111, 4'b1111, 4'b0000};
    tbl[1]  = '{1'b0, 4'b1111, 4'b1111, 4'b0001};
    tbl[2]  = '{1'b0, 4'b1111, 4'b1111, 4'b0010};
    tbl[3]  = '{1'b0, 4'b1111, 4'b1111, 4'b0100};
    tbl[4]  = '{1'b0, 4'b1111, 4'b1111, 4'b1000};
    tbl[5]  = '{1'b0, 4'b1111, 4'b1111, 4'b0001};
    tbl[6]  = '{1'b0, 4'b1111, 4'b1111, 4'b0010};
    tbl[7]  = '{1'b0, 4'b1111, 4'b1111, 4'b0100};
    tbl[8]  = '{1'b0, 4'b1111, 4'b1111, 4'b1000};
    tbl[9]  = '{1'b0, 4'b1111, 4'b1110, 4'b0001};
    tbl[10] = '{1'b0, 4'b1111, 4'b1110, 4'b0010};
    tbl[11] = '{1'b0, 4'b1111, 4'b1110, 4'b0100};
    tbl[12] = '{1'b0, 4'b1111, 4'b1110, 4'b1000};
    tbl[13] = '{1'b0, 4'b1111, 4'b1110, 4'b0010};
    tbl[14] = '{1'b0, 4'b0001, 4'b1111, 4'b0001};
    tbl[15] = '{1'b0, 4'b0000, 4'b1111, 4'b0000};

    drive(1'b1, '0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state and round-robin / backpressure table.
    ch0_acc = 0;
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst, tbl[i].rv, 4'b0000, tbl[i].rr, '0, '0);
      do_cycle();
      chk($sformatf("tbl_ready_row%0d", i), 32'(last_rdy), 32'(tbl[i].exp));
      if (i >= 9 && i <= 13 && last_rdy[0]) ch0_acc++;
    end
    chk("bp_ch0_accepts", 32'(ch0_acc), 32'd1);

    // Read after reset returns zero with latency 1.
    drive(1'b1, '0, '0, '0, '0, '0);
    do_cycle();
    one(0, 1'b0, 5, 32'h0, 4'hF);
    do_cycle();
    chk("rst_rd_grant", 32'(last_g), 32'd0);
    chk("rst_rd_valid", 32'(rvl[0][0]), 32'd1);
    chk("rst_rd_rdata", rdt[0][31:0], 32'h0);
    chk("rst_rd_err", 32'(rer[0][0]), 32'd0);
    drive(1'b0, '0, '0, 4'hF, '0, '0);
    do_cycle();

    // Write on ch1 then read on ch2 on consecutive accepts.
    one(1, 1'b1, 3, 32'hDEADBEEF, 4'hF);
    do_cycle();
    one(2, 1'b0, 3, 32'h0, 4'hF);
    do_cycle();
    chk("wr_rd_valid", 32'(rvl[0][2]), 32'd1);
    chk("wr_rd_d16", rdt[0][64 +: 32], 32'hDEADBEEF);
    chk("wr_rd_d12", rdt[1][64 +: 32], 32'hDEADBEEF);

    // Out-of-range address on the DEPTH=12 instance.
    one(0, 1'b1, 1, 32'h0000A5A5, 4'hF);
    do_cycle();
    one(3, 1'b1, 13, 32'h00001234, 4'hF);
    do_cycle();
    chk("aerr_wr_err12", 32'(rer[1][3]), 32'd1);
    chk("aerr_wr_rdata12", rdt[1][96 +: 32], 32'h0);
    chk("aerr_wr_err16", 32'(rer[0][3]), 32'd0);
    one(3, 1'b0, 13, 32'h0, 4'hF);
    do_cycle();
    chk("aerr_rd_err12", 32'(rer[1][3]), 32'd1);
    chk("aerr_rd_rdata16", rdt[0][96 +: 32], 32'h00001234);
    one(3, 1'b0, 1, 32'h0, 4'hF);
    do_cycle();
    chk("aerr_alias_d12", rdt[1][96 +: 32], 32'h0000A5A5);
    chk("aerr_alias_err", 32'(rer[1][3]), 32'd0);
    drive(1'b0, '0, '0, 4'hF, '0, '0);
    do_cycle();

    // Reset with stalled responses on ch0 and ch2.
    one(0, 1'b0, 2, 32'h0, 4'h0);
    do_cycle();
    one(2, 1'b0, 2, 32'h0, 4'h0);
    do_cycle();
    chk("mid_rst_pre", 32'(rvl[0]), 32'b0101);
    drive(1'b1, 4'hF, 4'h0, 4'h0, '0, '0);
    do_cycle();
    chk("mid_rst_valid16", 32'(rvl[0]), 32'h0);
    chk("mid_rst_valid12", 32'(rvl[1]), 32'h0);
    one(1, 1'b0, 1, 32'h0, 4'hF);
    do_cycle();
    chk("mid_rst_mem", rdt[0][32 +: 32], 32'h0);
    chk("mid_rst_resp", 32'(rvl[0]), 32'b0010);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 99) == 0, 4'($urandom), 4'($urandom),
            4'($urandom | $urandom), 16'($urandom),
            {$urandom, $urandom, $urandom, $urandom});
      do_cycle();
    end
    drive(1'b0, '0, '0, 4'hF, '0, '0);
    do_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
